xbox_mem_arb: RTL and testbench
===============================

# xbox_mem_arb

Round-robin arbiter that shares one XBOX-mastered memory instance between `NUM_REQ` accelerator engines (e.g. several matmul datapaths). It sits between the engines' memory request ports and one `xlr_mem_*` port slice. It issues at most one access per cycle and routes read data back to the requester that issued the read one cycle earlier. An optional lock mode lets one engine own the port for a bounded burst.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `LOG2_LINES_PER_MEM`, 4, address width of the memory
- `MAX_LOCK`, 8, maximum consecutive locked grants before forced release (1..255)
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_addr`  in  [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0]  per-requester line address
- `req_wdata`  in  [NUM_REQ-1:0][7:0][31:0]  per-requester write line (8 words)
- `req_be`  in  [NUM_REQ-1:0][31:0]  per-requester byte enables
- `req_rd`  in  [NUM_REQ-1:0]  read request
- `req_wr`  in  [NUM_REQ-1:0]  write request
- `req_lock`  in  [NUM_REQ-1:0]  request to hold the port after the current grant
- `gnt`  out  [NUM_REQ-1:0]  one-hot grant, same cycle as issue
- `rvalid`  out  [NUM_REQ-1:0]  one-hot: `rdata` belongs to this requester
- `rdata`  out  [7:0][31:0]  read line, broadcast to all requesters
- `err`  out  1  sticky: some requester asserted rd and wr together
- `mem_addr`  out  [LOG2_LINES_PER_MEM-1:0]  to memory
- `mem_wdata`  out  [7:0][31:0]  to memory
- `mem_be`  out  [31:0]  to memory
- `mem_rd`, `mem_wr`  out  1 each  to memory
- `mem_rdata`  in  [7:0][31:0]  from memory; valid the cycle after `mem_rd`

## Operation
- Request active for requester i: `req_rd[i] | req_wr[i]`. A requester holds its request and payload stable until it sees `gnt[i]`.
- Grant selection: the first active requester searching upward from `rr_ptr`, wrapping at NUM_REQ-1 to 0. At most one `gnt` bit is set.
- `mem_*` outputs are combinationally muxed from the granted requester. When nothing is granted they are all zero; `mem_rd`/`mem_wr` are never asserted without a grant.
- If `rd` and `wr` are both high for the granted requester, the access is performed as a write and `err` is set. `err` is cleared only by reset.
- Pointer update on a grant to i while not locked: `rr_ptr` <= (i+1) mod NUM_REQ. No grant: pointer holds.
- Read return: on a granted read to i, register `rd_pend`=1 and `rd_id`=i. Next cycle, `rvalid[rd_id]`=1 and `rdata`=`mem_rdata`. `rdata` is don't-care when `rvalid`=0.
- State machine (two states, plus `lock_cnt`):
  - ARB → LOCKED: grant to i with `req_lock[i]`=1. Set `lock_owner`=i, `lock_cnt`=1.
  - LOCKED: only `lock_owner` may be granted; all others get no grant.
    - Owner requests: grant, and `lock_cnt`++.
    - LOCKED → ARB when the owner drops `req_lock`, or after a grant that makes `lock_cnt`==MAX_LOCK. On exit, `rr_ptr` <= owner+1.
    - Owner idle with lock still high: port stays idle and held, and `lock_cnt` does not advance.

## Timing
- Grant-to-issue latency 0 cycles. Read data latency 1 cycle after grant.
- Throughput: one access per cycle. Back-to-back reads from different requesters give back-to-back `rvalid` bits.
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `err`=0, all `mem_*`=0, `rr_ptr`=0, state ARB, `lock_cnt`=0, `rd_pend`=0.
- Reset asserted mid-operation: a pending read return is dropped (no `rvalid`) and any lock is released.
- A requester may raise a new request in the same cycle it receives `rvalid`.

## Configuration
- `XBOX_ARB_LOCK_EN` defined: lock behaviour as in Operation.
- Not defined: `req_lock` is ignored, the LOCKED state and `lock_cnt` are not built, and arbitration is pure round-robin every cycle.

## Structure
- Package `xbox_arb_pkg`:
  - `mem_line_t` (logic [7:0][31:0]) and `mem_be_t` (logic [31:0])
  - state enum `arb_state_e` {ARB, LOCKED}
  - default `MAX_LOCK` constant
- Sub-module `xbox_rr_pick`: purely combinational. Takes the request vector and `rr_ptr`; returns a one-hot grant and its index. Instantiated once.

## Test plan
- Single requester: r1 reads addr 3 with mem line 3 = {8{32'hA5A5_0003}} → `gnt`=4'b0010 in cycle 0; `rvalid`=4'b0010 and `rdata`=that line in cycle 1.
- All four request continuously from reset → grants 0,1,2,3,0,… one per cycle; every read's `rvalid` lands on the correct requester.
- r2 write addr 5 `be`=32'h0000_000F in the same cycle as r0 read addr 5 (`rr_ptr`=2) → r2 written first, r0 next cycle, and r0 reads back the new word 0.
- Lock (macro on): r1 holds lock and requests for 12 cycles while r3 requests → r1 is granted 8 consecutive times, then r3 is granted, then r1 again.
- `req_rd[0]`=`req_wr[0]`=1 → `mem_wr`=1, `mem_rd`=0, and `err` goes to 1 and stays there until `rst_n`=0.
- Read granted, then `rst_n` low in the next cycle → `rvalid`=0 and all outputs 0; after release, the first grant goes to r0.

Source files
------------

// File: rtl/xbox_arb_pkg.sv
// Shared types and constants for the XBOX memory-port arbiter.
package xbox_arb_pkg;

   typedef logic [7:0][31:0] mem_line_t;
   typedef logic [31:0]      mem_be_t;

   typedef enum logic {ARB, LOCKED} arb_state_e;

   localparam int MAX_LOCK_DEF = 8;

endpackage

// File: rtl/xbox_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module xbox_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   int               j;
   logic [IDX_W-1:0] jj;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = IDX_W'(j);
         if (!any_o && req_i[jj]) begin
            any_o     = 1'b1;
            gnt_o[jj] = 1'b1;
            idx_o     = jj;
         end
      end
   end

endmodule

// File: rtl/xbox_mem_arb.sv
// Round-robin arbiter sharing one xlr_mem port between NUM_REQ engines.
// Optional bounded-burst lock mode is built only when XBOX_ARB_LOCK_EN is defined.
//
// state  | meaning
// ARB    | plain round-robin among all active requesters
// LOCKED | only lock_owner may be granted, until lock drops or MAX_LOCK grants
module xbox_mem_arb
   import xbox_arb_pkg::*;
#(
   parameter int NUM_REQ            = 4,
   parameter int LOG2_LINES_PER_MEM = 4,
   parameter int MAX_LOCK           = MAX_LOCK_DEF
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0]    req_addr,
   input  logic [NUM_REQ-1:0][7:0][31:0]                 req_wdata,
   input  logic [NUM_REQ-1:0][31:0]                      req_be,
   input  logic [NUM_REQ-1:0]                            req_rd,
   input  logic [NUM_REQ-1:0]                            req_wr,
   input  logic [NUM_REQ-1:0]                            req_lock,
   output logic [NUM_REQ-1:0]                            gnt,
   output logic [NUM_REQ-1:0]                            rvalid,
   output mem_line_t                                     rdata,
   output logic                                          err,
   output logic [LOG2_LINES_PER_MEM-1:0]                 mem_addr,
   output mem_line_t                                     mem_wdata,
   output mem_be_t                                       mem_be,
   output logic                                          mem_rd,
   output logic                                          mem_wr,
   input  mem_line_t                                     mem_rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);

   function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

   logic [NUM_REQ-1:0] active;
   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               rd_pend_q, rd_pend_d;
   logic [IDX_W-1:0]   rd_id_q, rd_id_d;
   logic               err_q, err_d;
   logic               rd_sel, wr_sel;

   // Gating with rst_n keeps the combinational grant path quiet while reset is held.
   assign active = (req_rd | req_wr) & {NUM_REQ{rst_n}};

   xbox_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i (pick_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

`ifdef XBOX_ARB_LOCK_EN
   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [7:0]       lock_cnt_q, lock_cnt_d;

   always_comb begin
      pick_req = active;
      if (state_q == LOCKED) begin
         pick_req           = '0;
         pick_req[owner_q]  = active[owner_q];
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         ARB: begin
            if (pick_any) begin
               rr_ptr_d = nxt_idx(pick_idx);
               // With MAX_LOCK of 1 the entering grant already exhausts the burst.
               if (req_lock[pick_idx] && (MAX_LOCK > 1)) begin
                  state_d    = LOCKED;
                  owner_d    = pick_idx;
                  lock_cnt_d = 8'd1;
               end
            end
         end
         LOCKED: begin
            if (pick_any) lock_cnt_d = lock_cnt_q + 8'd1;
            if (!req_lock[owner_q] ||
                (pick_any && (lock_cnt_q == 8'(MAX_LOCK - 1)))) begin
               state_d    = ARB;
               lock_cnt_d = '0;
               rr_ptr_d   = nxt_idx(owner_q);
            end
         end
         default: begin
            state_d    = ARB;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         owner_q    <= '0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;

   assign pick_req = active;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (pick_any) rr_ptr_d = nxt_idx(pick_idx);
   end
`endif

   assign gnt = pick_gnt;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      rd_sel    = 1'b0;
      wr_sel    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            mem_addr  = req_addr[i];
            mem_wdata = req_wdata[i];
            mem_be    = req_be[i];
            rd_sel    = req_rd[i];
            wr_sel    = req_wr[i];
         end
      end
   end

   // A simultaneous rd+wr is resolved as a write and flagged.
   assign mem_wr = wr_sel;
   assign mem_rd = rd_sel & ~wr_sel;

   assign err_d     = err_q | (rd_sel & wr_sel);
   assign rd_pend_d = mem_rd;
   assign rd_id_d   = pick_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      rvalid = '0;
      if (rd_pend_q) rvalid[rd_id_q] = 1'b1;
   end

   assign rdata = rd_pend_q ? mem_rdata : '0;
   assign err   = err_q;

endmodule

// File: tb/tb_xbox_mem_arb.sv
// Scoreboard bench for xbox_mem_arb; lock-burst vectors run when XBOX_ARB_LOCK_EN is defined.
module tb_xbox_mem_arb;
   import xbox_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0][AW-1:0] req_addr;
   mem_line_t [N-1:0]    req_wdata;
   logic [N-1:0][31:0]   req_be;
   logic [N-1:0]         req_rd, req_wr, req_lock;
   logic [N-1:0]         gnt, rvalid;
   mem_line_t            rdata, mem_wdata, mem_rdata;
   logic                 err;
   logic [AW-1:0]        mem_addr;
   mem_be_t              mem_be;
   logic                 mem_rd, mem_wr;

   xbox_mem_arb #(.NUM_REQ(N), .LOG2_LINES_PER_MEM(AW), .MAX_LOCK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .req_rd    (req_rd),
      .req_wr    (req_wr),
      .req_lock  (req_lock),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata)
   );

   function automatic mem_line_t line_of(input int a);
      mem_line_t l;
      for (int w = 0; w < 8; w++) l[w] = 32'hA5A5_0000 | 32'(a);
      return l;
   endfunction

   // Memory instance: 1-cycle read latency, byte-enabled writes.
   mem_line_t mem [16];
   logic      loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int a = 0; a < 16; a++) mem[a] <= line_of(a);
         mem_rdata <= '0;
         loaded    <= 1'b1;
      end else begin
         if (mem_rd) mem_rdata <= mem[mem_addr];
         if (mem_wr)
            for (int b = 0; b < 32; b++)
               if (mem_be[b]) mem[mem_addr][b/4][8*(b%4) +: 8] <= mem_wdata[b/4][8*(b%4) +: 8];
      end
   end

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [31:0]   be;
      mem_line_t     wdata;
   } g_t;

   typedef struct packed {
      logic [N-1:0] rv;
      mem_line_t    data;
   } r_t;

   g_t gq[$];
   r_t rq[$];
   g_t ge;
   r_t re;
   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_g(input logic [N-1:0] g, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [31:0] be, input mem_line_t wd);
      g_t e;
      e.gnt = g; e.rd = rd; e.wr = wr; e.addr = a; e.be = be; e.wdata = wd;
      gq.push_back(e);
   endtask

   task automatic push_r(input logic [N-1:0] rv, input mem_line_t d);
      r_t e;
      e.rv = rv; e.data = d;
      rq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every presented grant and read return against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt != '0) begin
            if (gq.size() == 0) chk("unexpected_gnt", gnt, '0);
            else begin
               ge = gq.pop_front();
               chk("gnt", gnt, ge.gnt);
               chk("mem_rd", mem_rd, ge.rd);
               chk("mem_wr", mem_wr, ge.wr);
               chk("mem_addr", mem_addr, ge.addr);
               if (ge.wr) begin
                  chk("mem_be", mem_be, ge.be);
                  chk("mem_wdata", mem_wdata, ge.wdata);
               end
            end
         end else begin
            chk("idle_mem", {mem_rd, mem_wr, mem_addr, mem_be}, '0);
         end
         if (rvalid != '0) begin
            if (rq.size() == 0) chk("unexpected_rvalid", rvalid, '0);
            else begin
               re = rq.pop_front();
               chk("rvalid", rvalid, re.rv);
               chk("rdata", rdata, re.data);
            end
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_gnt"}, gnt, '0);
      chk({nm, "_rvalid"}, rvalid, '0);
      chk({nm, "_rdata"}, rdata, '0);
      chk({nm, "_err"}, err, 1'b0);
      chk({nm, "_mem"}, {mem_rd, mem_wr, mem_addr, mem_be}, '0);
      chk({nm, "_mem_wdata"}, mem_wdata, '0);
   endtask

   mem_line_t wd, nl;

   initial begin
      rst_n = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      req_rd = '0; req_wr = '0; req_lock = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      step();
      rst_n = 1'b1;

      // All four read continuously: grants rotate 0,1,2,3,0,...
      for (int i = 0; i < N; i++) begin
         req_rd[i]   = 1'b1;
         req_addr[i] = AW'(i);
      end
      for (int k = 0; k < 8; k++) begin
         push_g(N'(1) << (k % 4), 1'b1, 1'b0, AW'(k % 4), 32'h0, '0);
         push_r(N'(1) << (k % 4), line_of(k % 4));
      end
      repeat (8) step();
      req_rd = '0;
      repeat (2) step();

      // Single requester r1 reads line 3.
      req_rd[1] = 1'b1; req_addr[1] = 4'd3;
      push_g(4'b0010, 1'b1, 1'b0, 4'd3, 32'h0, '0);
      push_r(4'b0010, line_of(3));
      step();
      req_rd[1] = 1'b0;
      repeat (2) step();

      // rr_ptr is 2: r2 writes word 0 of line 5, then r0 reads it back.
      wd = {8{32'h1111_1111}};
      wd[0] = 32'hDEAD_BEEF;
      nl = line_of(5);
      nl[0] = 32'hDEAD_BEEF;
      req_wr[2] = 1'b1; req_addr[2] = 4'd5; req_be[2] = 32'h0000_000F; req_wdata[2] = wd;
      req_rd[0] = 1'b1; req_addr[0] = 4'd5;
      push_g(4'b0100, 1'b0, 1'b1, 4'd5, 32'h0000_000F, wd);
      push_g(4'b0001, 1'b1, 1'b0, 4'd5, 32'h0, '0);
      push_r(4'b0001, nl);
      step();
      req_wr[2] = 1'b0; req_be[2] = '0; req_wdata[2] = '0;
      step();
      req_rd[0] = 1'b0;
      repeat (2) step();

      // rd and wr together on r0: performed as a write, err becomes sticky.
      chk("err_before", err, 1'b0);
      req_rd[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 4'd7;
      push_g(4'b0001, 1'b0, 1'b1, 4'd7, 32'h0, '0);
      step();
      req_rd[0] = 1'b0; req_wr[0] = 1'b0;
      chk("err_set", err, 1'b1);
      repeat (3) step();
      chk("err_sticky", err, 1'b1);

      // Read granted, reset in the next cycle drops the return.
      req_rd[1] = 1'b1; req_addr[1] = 4'd3;
      push_g(4'b0010, 1'b1, 1'b0, 4'd3, 32'h0, '0);
      step();
      req_rd[1] = 1'b0;
      rst_n = 1'b0;
      req_rd[0] = 1'b1; req_addr[0] = 4'd1;
      req_rd[2] = 1'b1; req_addr[2] = 4'd2;
      @(negedge clk);
      chk_all_zero("mid_reset");
      step();
      step();
      push_g(4'b0001, 1'b1, 1'b0, 4'd1, 32'h0, '0);
      push_r(4'b0001, line_of(1));
      push_g(4'b0100, 1'b1, 1'b0, 4'd2, 32'h0, '0);
      push_r(4'b0100, line_of(2));
      rst_n = 1'b1;
      step();
      req_rd[0] = 1'b0;
      step();
      req_rd[2] = 1'b0;
      repeat (2) step();

`ifdef XBOX_ARB_LOCK_EN
      // r1 locks for a burst while r3 waits: 8 x r1, r3, then r1 again.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_rd[1] = 1'b1; req_lock[1] = 1'b1; req_addr[1] = 4'd1;
      req_rd[3] = 1'b1; req_addr[3] = 4'd3;
      for (int k = 0; k < 12; k++) begin
         if (k == 8) begin
            push_g(4'b1000, 1'b1, 1'b0, 4'd3, 32'h0, '0);
            push_r(4'b1000, line_of(3));
         end else begin
            push_g(4'b0010, 1'b1, 1'b0, 4'd1, 32'h0, '0);
            push_r(4'b0010, line_of(1));
         end
      end
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 8) req_rd[3] = 1'b0;
      end
      req_rd[1] = 1'b0; req_lock[1] = 1'b0;
      repeat (2) step();
`endif

      chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
      chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
